// File: rtl/rv_decode_idex_stage.sv
// ============================================================================
// Module  : rv_decode_idex_stage
// Brief   : RV32I decode stage with writeback bypass, load-use hazard
//           detection and the ID/EX pipeline register.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_decode_idex_stage #(
    parameter bit WB_BYPASS      = 1'b1,
    parameter bit LOAD_USE_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_pc_rel,
    output logic        ex_illegal
);

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [3:0] c_ALU_ADD    = 4'b0000;
    localparam logic [3:0] c_ALU_SUB    = 4'b1000;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7_5;
    logic [4:0]  w_rs1_fld;
    logic [4:0]  w_rs2_fld;
    logic [4:0]  w_rd_fld;

    assign w_opcode   = if_instr[6:0];
    assign w_rd_fld   = if_instr[11:7];
    assign w_funct3   = if_instr[14:12];
    assign w_rs1_fld  = if_instr[19:15];
    assign w_rs2_fld  = if_instr[24:20];
    assign w_funct7_5 = if_instr[30];

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign w_imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign w_imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};
    assign w_imm_u = {if_instr[31:12], 12'h000};
    assign w_imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};

    // Decoded control
    logic [31:0] w_imm;
    logic [3:0]  w_alu_op;
    logic        w_alu_src;
    logic        w_reg_write;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_branch;
    logic        w_jump;
    logic        w_pc_rel;
    logic        w_illegal;
    logic        w_use_rs1;
    logic        w_use_rs2;

    always_comb begin
        w_imm       = 32'h0;
        w_alu_op    = c_ALU_ADD;
        w_alu_src   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_pc_rel    = 1'b0;
        w_illegal   = 1'b0;
        w_use_rs1   = 1'b1;
        w_use_rs2   = 1'b0;
        case (w_opcode)
            c_OPC_LUI: begin
                w_imm       = w_imm_u;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_use_rs1   = 1'b0;
            end
            c_OPC_AUIPC: begin
                w_imm       = w_imm_u;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_pc_rel    = 1'b1;
            end
            c_OPC_JAL: begin
                w_imm       = w_imm_j;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_jump      = 1'b1;
                w_pc_rel    = 1'b1;
                w_use_rs1   = 1'b0;
            end
            c_OPC_JALR: begin
                w_imm       = w_imm_i;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_jump      = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_imm       = w_imm_b;
                w_alu_op    = c_ALU_SUB;
                w_branch    = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_OPC_LOAD: begin
                w_imm       = w_imm_i;
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
            end
            c_OPC_STORE: begin
                w_imm       = w_imm_s;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_OPC_OPIMM: begin
                // Only the shift-right pair uses bit 30 to pick SRAI over SRLI
                w_imm       = w_imm_i;
                w_alu_op    = {(w_funct3 == 3'b101) ? w_funct7_5 : 1'b0, w_funct3};
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_OP: begin
                w_alu_op    = {w_funct7_5, w_funct3};
                w_reg_write = 1'b1;
                w_use_rs2   = 1'b1;
            end
            default: begin
                w_illegal   = 1'b1;
                w_use_rs1   = 1'b0;
            end
        endcase
    end

    logic [4:0] w_rf_a1;
    logic [4:0] w_rf_a2;
    logic [4:0] w_rd;

    assign w_rf_a1 = w_use_rs1   ? w_rs1_fld : 5'd0;
    assign w_rf_a2 = w_use_rs2   ? w_rs2_fld : 5'd0;
    assign w_rd    = w_reg_write ? w_rd_fld  : 5'd0;
    assign rf_a1   = w_rf_a1;
    assign rf_a2   = w_rf_a2;

    // Operand read with optional same-cycle writeback forwarding
    logic w_byp1;
    logic w_byp2;

    generate
        if (WB_BYPASS) begin : g_wb_bypass
            assign w_byp1 = wb_we && (wb_rd != 5'd0) && (wb_rd == w_rf_a1);
            assign w_byp2 = wb_we && (wb_rd != 5'd0) && (wb_rd == w_rf_a2);
        end else begin : g_no_wb_bypass
            assign w_byp1 = 1'b0;
            assign w_byp2 = 1'b0;
        end
    endgenerate

    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1_val = (w_rf_a1 == 5'd0) ? 32'h0 : (w_byp1 ? wb_wd : rf_rd1);
    assign w_rs2_val = (w_rf_a2 == 5'd0) ? 32'h0 : (w_byp2 ? wb_wd : rf_rd2);

    // Pipeline register state
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_val;
    logic [31:0] r_rs2_val;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [3:0]  r_alu_op;
    logic        r_alu_src;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_branch;
    logic        r_jump;
    logic        r_pc_rel;
    logic        r_illegal;

    // Load in EX whose result is needed by the instruction in decode
    logic w_hazard;

    generate
        if (LOAD_USE_CHECK) begin : g_load_use
            assign w_hazard = r_valid && r_mem_read && (r_rd != 5'd0) &&
                              ((r_rd == w_rf_a1) || (r_rd == w_rf_a2));
        end else begin : g_no_load_use
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign id_ready = ex_ready & ~w_hazard;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_valid     <= 1'b0;
            r_pc        <= 32'h0;
            r_rs1_val   <= 32'h0;
            r_rs2_val   <= 32'h0;
            r_imm       <= 32'h0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_funct3    <= 3'd0;
            r_alu_op    <= 4'd0;
            r_alu_src   <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_pc_rel    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_valid     <= 1'b0;
        end else if (!ex_ready) begin
            r_valid     <= r_valid;
        end else if (w_hazard) begin
            r_valid     <= 1'b0;
        end else begin
            r_valid     <= if_valid;
            r_pc        <= if_pc;
            r_rs1_val   <= w_rs1_val;
            r_rs2_val   <= w_rs2_val;
            r_imm       <= w_imm;
            r_rs1       <= w_rf_a1;
            r_rs2       <= w_rf_a2;
            r_rd        <= w_rd;
            r_funct3    <= w_funct3;
            r_alu_op    <= w_alu_op;
            r_alu_src   <= w_alu_src;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_branch    <= w_branch;
            r_jump      <= w_jump;
            r_pc_rel    <= w_pc_rel;
            r_illegal   <= w_illegal;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_rs1_val   = r_rs1_val;
    assign ex_rs2_val   = r_rs2_val;
    assign ex_imm       = r_imm;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_funct3    = r_funct3;
    assign ex_alu_op    = r_alu_op;
    assign ex_alu_src   = r_alu_src;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_branch    = r_branch;
    assign ex_jump      = r_jump;
    assign ex_pc_rel    = r_pc_rel;
    assign ex_illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_rv_decode_idex_stage.sv
// ============================================================================
// Module  : tb_rv_decode_idex_stage
// Brief   : Directed self-checking bench for rv_decode_idex_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_decode_idex_stage;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic [31:0] rf_rd1 = 32'h0;
    logic [31:0] rf_rd2 = 32'h0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_wd = 32'h0;

    logic        id_ready, ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_jump, ex_pc_rel, ex_illegal;
    logic [4:0]  rf_a1, rf_a2, ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_alu_op;

    logic        nb_id_ready, nb_ex_valid, nb_ex_alu_src, nb_ex_reg_write, nb_ex_mem_read;
    logic        nb_ex_mem_write, nb_ex_branch, nb_ex_jump, nb_ex_pc_rel, nb_ex_illegal;
    logic [4:0]  nb_rf_a1, nb_rf_a2, nb_ex_rs1, nb_ex_rs2, nb_ex_rd;
    logic [31:0] nb_ex_pc, nb_ex_rs1_val, nb_ex_rs2_val, nb_ex_imm;
    logic [2:0]  nb_ex_funct3;
    logic [3:0]  nb_ex_alu_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv_decode_idex_stage dut (
        .clk(clk), .areset(areset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .rf_a1(rf_a1), .rf_a2(rf_a2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_pc_rel(ex_pc_rel), .ex_illegal(ex_illegal)
    );

    rv_decode_idex_stage #(.WB_BYPASS(1'b0)) dut_nb (
        .clk(clk), .areset(areset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(nb_id_ready), .flush(flush), .ex_ready(ex_ready), .rf_a1(nb_rf_a1),
        .rf_a2(nb_rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_wd(wb_wd), .ex_valid(nb_ex_valid), .ex_pc(nb_ex_pc), .ex_rs1_val(nb_ex_rs1_val),
        .ex_rs2_val(nb_ex_rs2_val), .ex_imm(nb_ex_imm), .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2),
        .ex_rd(nb_ex_rd), .ex_funct3(nb_ex_funct3), .ex_alu_op(nb_ex_alu_op),
        .ex_alu_src(nb_ex_alu_src), .ex_reg_write(nb_ex_reg_write),
        .ex_mem_read(nb_ex_mem_read), .ex_mem_write(nb_ex_mem_write),
        .ex_branch(nb_ex_branch), .ex_jump(nb_ex_jump), .ex_pc_rel(nb_ex_pc_rel),
        .ex_illegal(nb_ex_illegal)
    );

    // Advance one rising edge, then settle 1 time unit away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", ex_valid); end
        checks++; if (ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", ex_pc); end
        checks++; if ({ex_imm, ex_rd, ex_alu_op, ex_illegal} !== 42'h0) begin errors++; $display("FAIL reset_fields: got %h exp 0", {ex_imm, ex_rd, ex_alu_op, ex_illegal}); end
        step();
        #2 areset = 1'b0;
    endtask

    task automatic test_fetch();
        step();
        if_valid = 1'b1; ex_ready = 1'b1; if_pc = 32'h100;
        if_instr = 32'h00500093; rf_rd1 = 32'hDEAD;
        #1;
        checks++; if (rf_a1 !== 5'd0) begin errors++; $display("FAIL fetch_rf_a1: got %0d exp 0", rf_a1); end
        checks++; if (rf_a2 !== 5'd0) begin errors++; $display("FAIL fetch_rf_a2: got %0d exp 0", rf_a2); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL fetch_id_ready: got %b exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b exp 1", ex_valid); end
        checks++; if (ex_imm !== 32'h5) begin errors++; $display("FAIL fetch_imm: got %h exp 5", ex_imm); end
        checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL fetch_rd: got %0d exp 1", ex_rd); end
        checks++; if (ex_alu_src !== 1'b1) begin errors++; $display("FAIL fetch_alu_src: got %b exp 1", ex_alu_src); end
        checks++; if (ex_alu_op !== 4'd0) begin errors++; $display("FAIL fetch_alu_op: got %h exp 0", ex_alu_op); end
        checks++; if (ex_rs1_val !== 32'h0) begin errors++; $display("FAIL fetch_rs1_val: got %h exp 0", ex_rs1_val); end
        checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL fetch_pc: got %h exp 100", ex_pc); end
        checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL fetch_reg_write: got %b exp 1", ex_reg_write); end
    endtask

    task automatic test_wb_bypass();
        // add x3,x2,x4 with writeback to x2 in the same cycle
        if_instr = 32'h004101B3; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        wb_we = 1'b1; wb_rd = 5'd2; wb_wd = 32'hAB;
        #1;
        checks++; if ({rf_a1, rf_a2} !== {5'd2, 5'd4}) begin errors++; $display("FAIL byp_addr: got %0d/%0d exp 2/4", rf_a1, rf_a2); end
        step();
        checks++; if (ex_rs1_val !== 32'hAB) begin errors++; $display("FAIL byp_rs1: got %h exp ab", ex_rs1_val); end
        checks++; if (ex_rs2_val !== 32'h22) begin errors++; $display("FAIL byp_rs2_noforward: got %h exp 22", ex_rs2_val); end
        checks++; if (nb_ex_rs1_val !== 32'h11) begin errors++; $display("FAIL nobyp_rs1: got %h exp 11", nb_ex_rs1_val); end
        checks++; if ({ex_alu_src, ex_imm} !== 33'h0) begin errors++; $display("FAIL rtype_imm: got %h exp 0", {ex_alu_src, ex_imm}); end
        checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL rtype_rd: got %0d exp 3", ex_rd); end
        // Forward into port 2 instead
        wb_rd = 5'd4; wb_wd = 32'hCD;
        step();
        checks++; if ({ex_rs1_val, ex_rs2_val} !== {32'h11, 32'hCD}) begin errors++; $display("FAIL byp_rs2: got %h/%h exp 11/cd", ex_rs1_val, ex_rs2_val); end
        // Write-enable low: no forwarding
        wb_we = 1'b0; wb_rd = 5'd2;
        step();
        checks++; if (ex_rs1_val !== 32'h11) begin errors++; $display("FAIL byp_we_low: got %h exp 11", ex_rs1_val); end
        // wb_rd = 0 against an x0 read: result must stay zero
        wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'hAB; if_instr = 32'h00500093;
        step();
        checks++; if (ex_rs1_val !== 32'h0) begin errors++; $display("FAIL byp_x0: got %h exp 0", ex_rs1_val); end
        wb_we = 1'b0;
    endtask

    task automatic test_alu_ops();
        if_instr = 32'h404101B3;  // sub x3,x2,x4
        step();
        checks++; if (ex_alu_op !== 4'b1000) begin errors++; $display("FAIL sub_alu_op: got %b exp 1000", ex_alu_op); end
        if_instr = 32'h40315093;  // srai x1,x2,3
        step();
        checks++; if ({ex_alu_op, ex_imm} !== {4'b1101, 32'h403}) begin errors++; $display("FAIL srai: got %b/%h exp 1101/403", ex_alu_op, ex_imm); end
        if_instr = 32'h40000093;  // addi x1,x0,0x400 (bit30 set, not a shift)
        step();
        checks++; if ({ex_alu_op, ex_imm} !== {4'b0000, 32'h400}) begin errors++; $display("FAIL addi_bit30: got %b/%h exp 0000/400", ex_alu_op, ex_imm); end
        if_instr = 32'hFE21AE23;  // sw x2,-4(x3)
        #1;
        checks++; if (rf_a2 !== 5'd2) begin errors++; $display("FAIL store_rf_a2: got %0d exp 2", rf_a2); end
        step();
        checks++; if ({ex_imm, ex_mem_write, ex_reg_write, ex_rd} !== {32'hFFFFFFFC, 1'b1, 1'b0, 5'd0}) begin errors++; $display("FAIL store: got imm %h we %b rw %b rd %0d exp fffffffc/1/0/0", ex_imm, ex_mem_write, ex_reg_write, ex_rd); end
        if_instr = 32'hFFDFF0EF;  // jal x1,-4
        #1;
        checks++; if (rf_a1 !== 5'd0) begin errors++; $display("FAIL jal_rf_a1: got %0d exp 0", rf_a1); end
        step();
        checks++; if ({ex_imm, ex_jump, ex_pc_rel, ex_rd} !== {32'hFFFFFFFC, 1'b1, 1'b1, 5'd1}) begin errors++; $display("FAIL jal: got imm %h j %b pr %b rd %0d exp fffffffc/1/1/1", ex_imm, ex_jump, ex_pc_rel, ex_rd); end
    endtask

    task automatic test_load_use();
        if_instr = 32'h00032283;  // lw x5,0(x6)
        step();
        checks++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd5}) begin errors++; $display("FAIL lw_in_ex: got %b/%b/%0d exp 1/1/5", ex_valid, ex_mem_read, ex_rd); end
        if_instr = 32'h001283B3;  // add x7,x5,x1
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hazard_id_ready: got %b exp 0", id_ready); end
        step();
        checks++; if ({ex_valid, ex_rd} !== {1'b0, 5'd5}) begin errors++; $display("FAIL bubble: got valid %b rd %0d exp 0/5", ex_valid, ex_rd); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bubble_release: got %b exp 1", id_ready); end
        step();
        checks++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd} !== {1'b1, 5'd5, 5'd1, 5'd7}) begin errors++; $display("FAIL add_after_bubble: got %b/%0d/%0d/%0d exp 1/5/1/7", ex_valid, ex_rs1, ex_rs2, ex_rd); end
        // I-type whose rs2 field matches the load: no hazard
        if_instr = 32'h00032283;
        step();
        if_instr = 32'h00508393;  // addi x7,x1,5
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL itype_no_hazard: got %b exp 1", id_ready); end
        step();
        // rs2 hazard coinciding with flush: flush wins, id_ready still low
        if_instr = 32'h00032283;
        step();
        if_instr = 32'h005083B3;  // add x7,x1,x5
        flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL rs2_hazard_id_ready: got %b exp 0", id_ready); end
        step();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_over_hazard: got %b exp 0", ex_valid); end
        step();
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin errors++; $display("FAIL add_after_flush: got %b/%0d exp 1/7", ex_valid, ex_rd); end
    endtask

    task automatic test_backpressure();
        if_instr = 32'h00500093; if_pc = 32'h200;
        step();
        ex_ready = 1'b0; if_instr = 32'h123454B7; if_pc = 32'h204;  // lui x9,0x12345
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_id_ready[%0d]: got %b exp 0", i, id_ready); end
            step();
            checks++; if ({ex_valid, ex_pc, ex_imm} !== {1'b1, 32'h200, 32'h5}) begin errors++; $display("FAIL bp_frozen[%0d]: got %b/%h/%h exp 1/200/5", i, ex_valid, ex_pc, ex_imm); end
        end
        checks++; if (rf_a1 !== 5'd0) begin errors++; $display("FAIL lui_rf_a1: got %0d exp 0", rf_a1); end
        ex_ready = 1'b1;
        step();
        checks++; if ({ex_pc, ex_imm, ex_rd} !== {32'h204, 32'h12345000, 5'd9}) begin errors++; $display("FAIL lui_load: got %h/%h/%0d exp 204/12345000/9", ex_pc, ex_imm, ex_rd); end
    endtask

    task automatic test_flush_imm();
        if_instr = 32'hFE000CE3;  // beq x0,x0,-8
        flush = 1'b1; ex_ready = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_beq: got %b exp 0", ex_valid); end
        flush = 1'b0; ex_ready = 1'b1;
        step();
        checks++; if ({ex_valid, ex_imm, ex_alu_op} !== {1'b1, 32'hFFFFFFF8, 4'b1000}) begin errors++; $display("FAIL beq: got %b/%h/%b exp 1/fffffff8/1000", ex_valid, ex_imm, ex_alu_op); end
        checks++; if ({ex_branch, ex_alu_src, ex_reg_write, ex_rd} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin errors++; $display("FAIL beq_ctrl: got %b%b%b rd %0d exp 100 rd 0", ex_branch, ex_alu_src, ex_reg_write, ex_rd); end
    endtask

    task automatic test_illegal_async_reset();
        if_instr = 32'h00A58F7F;  // opcode 0x7F, nonzero rd/rs fields
        #1;
        checks++; if ({rf_a1, rf_a2} !== 10'd0) begin errors++; $display("FAIL illegal_addr: got %0d/%0d exp 0/0", rf_a1, rf_a2); end
        step();
        checks++; if ({ex_illegal, ex_reg_write, ex_rd, ex_mem_read, ex_mem_write, ex_jump, ex_branch} !== {1'b1, 1'b0, 5'd0, 4'b0000}) begin errors++; $display("FAIL illegal: got il %b rw %b rd %0d mr %b mw %b j %b b %b", ex_illegal, ex_reg_write, ex_rd, ex_mem_read, ex_mem_write, ex_jump, ex_branch); end
        if_instr = 32'h00500093; if_pc = 32'h300;
        step();
        #2 areset = 1'b1;
        #1;
        checks++; if ({ex_valid, ex_pc} !== {1'b0, 32'h0}) begin errors++; $display("FAIL async_reset: got %b/%h exp 0/0", ex_valid, ex_pc); end
        areset = 1'b0;
        step();
        checks++; if ({ex_valid, ex_pc} !== {1'b1, 32'h300}) begin errors++; $display("FAIL after_reset: got %b/%h exp 1/300", ex_valid, ex_pc); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_wb_bypass();
        test_alu_ops();
        test_load_use();
        test_backpressure();
        test_flush_imm();
        test_illegal_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_decode_idex_stage.md
Name: rv_decode_idex_stage

Overview:
- Decode stage for the 32-bit RV32I core, plus the ID/EX pipeline register.
- Takes the fetched instruction and drives the register-file read addresses. It accepts the register-file read data and bypasses a same-cycle writeback into it.
- Generates the immediate and control fields, detects load-use hazards, and registers everything for EX with stall and flush support.

Parameters:
- WB_BYPASS, 1, 1 = forward the writeback port into the read data when addresses match; 0 = no forwarding.
- LOAD_USE_CHECK, 1, 1 = insert a bubble on a load-use hazard; 0 = never stall on hazard.

Ports:
- clk  in  1  rising-edge clock.
- areset  in  1  asynchronous, active-high reset.
- if_valid  in  1  if_instr/if_pc hold a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of the instruction.
- id_ready  out  1  stage accepts if_* this cycle.
- flush  in  1  kill the instruction in decode and the one entering EX.
- ex_ready  in  1  EX can take a new entry this cycle.
- rf_a1  out  5  rs1 = if_instr[19:15]; forced to 0 for LUI, JAL, illegal.
- rf_a2  out  5  rs2 = if_instr[24:20]; forced to 0 unless R-type, store or branch.
- rf_rd1  in  32  register-file read data, port 1 (combinational).
- rf_rd2  in  32  register-file read data, port 2 (combinational).
- wb_we  in  1  writeback enable (same signals as the register-file write port).
- wb_rd  in  5  writeback destination register.
- wb_wd  in  32  writeback data.
- ex_valid  out  1  EX entry valid.
- ex_pc  out  32  registered PC.
- ex_rs1_val  out  32  registered, bypassed rs1 value.
- ex_rs2_val  out  32  registered, bypassed rs2 value.
- ex_imm  out  32  sign-extended immediate.
- ex_rs1  out  5  registered rs1 index.
- ex_rs2  out  5  registered rs2 index.
- ex_rd  out  5  registered rd index (0 when no write).
- ex_funct3  out  3  registered funct3.
- ex_alu_op  out  4  ALU operation code.
- ex_alu_src  out  1  1 = operand B is the immediate.
- ex_reg_write  out  1  instruction writes rd.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_branch  out  1  conditional branch.
- ex_jump  out  1  JAL or JALR.
- ex_pc_rel  out  1  AUIPC/JAL: operand A is the PC.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- Reset: every ex_* output clears to 0 asynchronously while areset is high. rf_a1, rf_a2 and id_ready are combinational from the inputs.
- Operand read: a read of register 0 returns 0 regardless of rf_rdN.
- Writeback bypass: when WB_BYPASS=1, wb_we=1, wb_rd!=0 and wb_rd equals the read address, the value is wb_wd; otherwise it is rf_rdN. rs1 and rs2 are evaluated independently.
- Immediates, all sign-extended from instr[31]:
  - I-type: loads, OP-IMM, JALR.
  - S-type: stores.
  - B-type: branches, bit0 = 0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit0 = 0.
  - R-type: immediate is 0.
- alu_op:
  - R-type: {funct7[5], funct3}.
  - OP-IMM: {funct7[5] when funct3 = 101, else 0, funct3}.
  - Branch: 4'b1000 (SUB).
  - All others: 4'b0000 (ADD).
- Illegal opcode: ex_illegal = 1 and reg_write, mem_read, mem_write, branch and jump are all 0. rd = 0 whenever reg_write = 0.
- Hazard: asserted when LOAD_USE_CHECK=1, ex_valid=1, ex_mem_read=1, ex_rd!=0 and ex_rd equals a used source (rf_a1 or rf_a2, non-zero).
- id_ready = ex_ready & ~hazard (combinational; flush does not affect it).
- Register update at posedge clk, priority order:
  1. flush → ex_valid <= 0; other fields are don't-care but are held.
  2. !ex_ready → hold all ex_* unchanged.
  3. hazard → ex_valid <= 0 (bubble); other fields held.
  4. Otherwise → load all fields from decode, with ex_valid <= if_valid.
- Bubble latency: one cycle. On the next cycle ex_mem_read of the bubble is irrelevant because ex_valid = 0, so the hazard clears and the instruction advances.
- Latency: an instruction accepted at edge N is visible on ex_* after edge N.
- Reset mid-operation: the entry is discarded and ex_valid = 0. There is no replay; the fetch stage restarts from its reset PC.
- Simultaneous flush and hazard: flush wins. id_ready still reflects the hazard; upstream ignores id_ready during a flush.

Test Plan:
- Reset and fetch: areset pulse, then if_instr=0x00500093 (addi x1,x0,5), if_valid=1, ex_ready=1 → after one edge: ex_valid=1, ex_imm=5, ex_rd=1, ex_alu_src=1, ex_alu_op=0, ex_rs1_val=0.
- WB bypass: rf_rd1=0x11, wb_we=1, wb_rd=2, wb_wd=0xAB, instr add x3,x2,x4 → ex_rs1_val=0xAB. Repeat with WB_BYPASS=0 → ex_rs1_val=0x11. wb_rd=0 → no bypass.
- Load-use hazard: lw x5,0(x6) followed by add x7,x5,x1 → id_ready=0 for one cycle, one bubble (ex_valid=0), then the add enters with ex_rs1=5.
- Backpressure: ex_ready=0 for 3 cycles → ex_* frozen and id_ready=0. Release → the next instruction loads.
- Flush and immediates:
  - flush=1 with a valid beq → ex_valid=0.
  - Immediate check: beq x0,x0,-8 (0xFE000CE3) → ex_imm=0xFFFFFFF8, ex_alu_op=4'b1000.
  - Immediate check: lui x9,0x12345 → ex_imm=0x12345000.
- Illegal and async reset: opcode 0x7F → ex_illegal=1, ex_reg_write=0. areset asserted mid-clock → ex_valid=0 immediately, without waiting for a clock edge.
